// File: rtl/cm_pkg.sv
// Shared protocol bytes, FSM states and synchronizer depth for the CM bus arbiter.
package cm_pkg;

    localparam logic [7:0] CM_START = 8'h01;
    localparam logic [7:0] CM_BEGIN = 8'h02;
    localparam logic [7:0] CM_YES   = 8'h03;
    localparam logic [7:0] CM_NO    = 8'h04;
    localparam logic [7:0] CM_END   = 8'h05;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_SEND_START,
        ST_SEND_DATA,
        ST_SEND_END,
        ST_TURN,
        ST_WAIT_REPLY
    } state_t;

endpackage

// File: rtl/cm_edge_sync.sv
// Multi-flop synchronizer with per-bit rise/fall detection on the two newest stages.
module cm_edge_sync
    import cm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] stage [SYNC_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // stage[SYNC_DEPTH-1] is the older sample, stage[SYNC_DEPTH-2] the newer one
    assign q    = stage[SYNC_DEPTH-1];
    assign rise = ~stage[SYNC_DEPTH-1] &  stage[SYNC_DEPTH-2];
    assign fall =  stage[SYNC_DEPTH-1] & ~stage[SYNC_DEPTH-2];

endmodule

// File: rtl/cm_bus_arbiter.sv
// Round-robin arbiter sending START/payload/END frames on the CM bus and capturing the MCU reply.
// Optional reply-latency counter is built when CM_LATENCY_CNT_EN is defined.
module cm_bus_arbiter
    import cm_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int REPLY_TIMEOUT = 5_000_000
) (
    input  logic              CLK_50,
    input  logic              SW,
    input  logic              CLK_inter,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              drive_en,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_payload,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [7:0]        reply,
    output logic              reply_valid,
    output logic              timeout,
    output logic [31:0]       reply_cycles
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] TIMEOUT_LAST = (REPLY_TIMEOUT == 0) ? 32'd0 : 32'(REPLY_TIMEOUT - 1);

    state_t state, state_next;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] winner;
    logic             found;
    logic [7:0]       win_payload;
    logic [7:0]       payload;
    logic [31:0]      wait_cnt;

    logic       inter_q, inter_rise, inter_fall;
    logic [7:0] data_q, data_rise, data_fall;
    logic       reply_ok, timeout_hit;
    logic       unused_sync;

    cm_edge_sync #(.W(1)) u_inter_sync (
        .clk   (CLK_50),
        .reset (SW),
        .d     (CLK_inter),
        .q     (inter_q),
        .rise  (inter_rise),
        .fall  (inter_fall)
    );

    cm_edge_sync #(.W(8)) u_data_sync (
        .clk   (CLK_50),
        .reset (SW),
        .d     (data_in),
        .q     (data_q),
        .rise  (data_rise),
        .fall  (data_fall)
    );

    assign unused_sync = inter_q ^ inter_rise;

    // A reply byte counts only when two consecutive synchronized samples agree
    assign reply_ok    = ~|(data_rise | data_fall) && (data_q == CM_YES || data_q == CM_NO);
    assign timeout_hit = (REPLY_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        winner      = '0;
        found       = 1'b0;
        win_payload = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (PTR_W'(i) == winner) win_payload = req_payload[8*i +: 8];
        end
    end

    always_comb begin
        state_next = state;
        drive_en   = 1'b0;
        data_out   = 8'h00;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE:       if (|req) state_next = ST_ARB;
            ST_ARB:        state_next = found ? ST_SEND_START : ST_IDLE;
            ST_SEND_START: begin
                drive_en = 1'b1;
                data_out = CM_START;
                if (inter_fall) state_next = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
                drive_en = 1'b1;
                data_out = payload;
                if (inter_fall) state_next = ST_SEND_END;
            end
            ST_SEND_END: begin
                drive_en = 1'b1;
                data_out = CM_END;
                if (inter_fall) state_next = ST_TURN;
            end
            ST_TURN:       state_next = ST_WAIT_REPLY;
            ST_WAIT_REPLY: if (reply_ok || timeout_hit) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (SW) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            payload     <= 8'h00;
            reply       <= 8'h00;
            reply_valid <= 1'b0;
            timeout     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_next;
            reply_valid <= 1'b0;
            timeout     <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (found) begin
                        gnt     <= NREQ'(1) << winner;
                        payload <= win_payload;
                        ptr     <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                    end
                end
                ST_TURN: wait_cnt <= '0;
                ST_WAIT_REPLY: begin
                    // Reply takes priority over a coincident timeout
                    if (reply_ok) begin
                        reply       <= data_q;
                        reply_valid <= 1'b1;
                        gnt         <= '0;
                    end else if (timeout_hit) begin
                        timeout <= 1'b1;
                        gnt     <= '0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CM_LATENCY_CNT_EN
    logic [31:0] lat_cnt;

    always_ff @(posedge CLK_50) begin
        if (SW) begin
            lat_cnt      <= '0;
            reply_cycles <= '0;
        end else begin
            if (state == ST_TURN) begin
                lat_cnt <= '0;
            end else if (state == ST_WAIT_REPLY && lat_cnt != '1) begin
                lat_cnt <= lat_cnt + 32'd1;
            end
            if (state == ST_WAIT_REPLY && reply_ok) reply_cycles <= lat_cnt;
        end
    end
`else
    assign reply_cycles = '0;
`endif

endmodule

// File: tb/tb_cm_bus_arbiter.sv
// Self-checking bench for cm_bus_arbiter: directed scenarios plus randomized frames against a round-robin model.
module tb_cm_bus_arbiter;

    localparam int NREQ = 2;
`ifdef CM_LATENCY_CNT_EN
    localparam int TIMEOUT = 1000;
`else
    localparam int TIMEOUT = 100;
`endif

    logic              CLK_50;
    logic              SW;
    logic              CLK_inter;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              drive_en;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_payload;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [7:0]        reply;
    logic              reply_valid;
    logic              timeout;
    logic [31:0]       reply_cycles;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_ptr    = 0;
    logic [7:0] exp_reply = 8'h00;

    cm_bus_arbiter #(.NREQ(NREQ), .REPLY_TIMEOUT(TIMEOUT)) dut (
        .CLK_50       (CLK_50),
        .SW           (SW),
        .CLK_inter    (CLK_inter),
        .data_in      (data_in),
        .data_out     (data_out),
        .drive_en     (drive_en),
        .req          (req),
        .req_payload  (req_payload),
        .gnt          (gnt),
        .busy         (busy),
        .reply        (reply),
        .reply_valid  (reply_valid),
        .timeout      (timeout),
        .reply_cycles (reply_cycles)
    );

    initial CLK_50 = 1'b0;
    always #10 CLK_50 = ~CLK_50;

    // Round-robin reference: first requester at or after the pointer, wrapping
    function automatic int model_pick(input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (model_ptr + k) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        SW = 1'b1; req = '0; CLK_inter = 1'b0; data_in = 8'h00;
        repeat (3) @(negedge CLK_50);
        SW = 1'b0;
        model_ptr = 0;
        exp_reply = 8'h00;
        @(negedge CLK_50);
    endtask

    task automatic inter_pulse();
        CLK_inter = 1'b1;
        repeat (4) @(negedge CLK_50);
        CLK_inter = 1'b0;
    endtask

    // Plays three MCU clock pulses, capturing the byte shown before each; returns in the TURN cycle
    task automatic run_frame(output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2,
                             output logic [NREQ-1:0] g, output bit ok);
        logic [7:0] bytes [3];
        int k;
        ok = 1'b1;
        k = 0;
        while (!drive_en && k < 30) begin @(negedge CLK_50); k++; end
        if (!drive_en) ok = 1'b0;
        g = gnt;
        for (int p = 0; p < 3; p++) begin
            bytes[p] = data_out;
            if (!drive_en) ok = 1'b0;
            inter_pulse();
            if (p < 2) begin
                repeat (4) @(negedge CLK_50);
            end else begin
                k = 0;
                do begin @(negedge CLK_50); k++; end while (drive_en && k < 10);
                if (drive_en) ok = 1'b0;
            end
        end
        b0 = bytes[0]; b1 = bytes[1]; b2 = bytes[2];
    endtask

    // Echoes our END byte for a while, then drives the reply for 3 cycles
    task automatic give_reply(input logic [7:0] b, input int echo_cycles,
                              output int valid_pulses, output int to_pulses,
                              output logic [NREQ-1:0] g_at, output logic busy_at);
        valid_pulses = 0; to_pulses = 0; g_at = '1; busy_at = 1'b1;
        data_in = 8'h05;
        for (int k = 0; k < echo_cycles + 12; k++) begin
            if (k == echo_cycles) data_in = b;
            if (k == echo_cycles + 3) data_in = 8'h00;
            @(negedge CLK_50);
            if (reply_valid) begin valid_pulses++; g_at = gnt; busy_at = busy; end
            if (timeout) to_pulses++;
        end
        data_in = 8'h00;
    endtask

    task automatic test_reset();
        SW = 1'b1; req = '0; CLK_inter = 1'b0; data_in = 8'h00; req_payload = '0;
        repeat (2) @(negedge CLK_50);
        tests_run++;
        if ({data_out, drive_en, gnt, busy, reply, reply_valid, timeout, reply_cycles} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got do=%h de=%b gnt=%b busy=%b reply=%h rv=%b to=%b rc=%0d, expected all 0",
                     data_out, drive_en, gnt, busy, reply, reply_valid, timeout, reply_cycles);
        end
        SW = 1'b0;
        @(negedge CLK_50);
    endtask

    task automatic test_single_request();
        logic [7:0] b0, b1, b2;
        logic [NREQ-1:0] g;
        bit ok;
        int w;
        w = model_pick(2'b01);
        model_ptr = (w + 1) % NREQ;
        req_payload = {8'h77, 8'h2A};
        req = 2'b01;
        @(negedge CLK_50);
        tests_run++;
        if (drive_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL latency_early: got drive_en=%b, expected 0", drive_en); end
        @(negedge CLK_50);
        tests_run++;
        if (drive_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL latency_2cyc: got drive_en=%b, expected 1", drive_en); end
        req = 2'b00;
        req_payload = {8'h77, 8'hC3};
        run_frame(b0, b1, b2, g, ok);
        tests_run++;
        if ({ok, b0, b1, b2} !== {1'b1, 8'h01, 8'h2A, 8'h05}) begin
            tests_failed++;
            $display("[TB] FAIL single_frame: got ok=%b bytes %h %h %h, expected ok=1 bytes 01 2a 05", ok, b0, b1, b2);
        end
        tests_run++;
        if (g !== 2'(1 << w)) begin tests_failed++; $display("[TB] FAIL single_gnt: got %b, expected %b", g, 2'(1 << w)); end
        tests_run++;
        if ({drive_en, data_out} !== 9'h000) begin
            tests_failed++;
            $display("[TB] FAIL turn_release: got drive_en=%b data_out=%h, expected 0 00", drive_en, data_out);
        end
    endtask

    task automatic test_reply();
        int vp, tp;
        logic [NREQ-1:0] g_at;
        logic busy_at;
        give_reply(8'h04, 4, vp, tp, g_at, busy_at);
        exp_reply = 8'h04;
        tests_run++;
        if ({reply, 32'(vp), 32'(tp)} !== {8'h04, 32'd1, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL reply_no: got reply=%h valid_pulses=%0d timeouts=%0d, expected 04 1 0", reply, vp, tp);
        end
        tests_run++;
        if ({g_at, busy_at} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reply_release: got gnt=%b busy=%b, expected 00 0", g_at, busy_at);
        end
        tests_run++;
        if (reply_cycles !== 32'd0) begin
`ifndef CM_LATENCY_CNT_EN
            tests_failed++;
            $display("[TB] FAIL reply_cycles_tied: got %0d, expected 0", reply_cycles);
`endif
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] b0, b1, b2, pl [NREQ];
        logic [NREQ-1:0] g;
        logic [7:0] rep;
        bit ok;
        int w, vp, tp;
        logic busy_at;
        do_reset();
        pl[0] = 8'($urandom); pl[1] = 8'($urandom);
        req_payload = {pl[1], pl[0]};
        req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            w = model_pick(req);
            model_ptr = (w + 1) % NREQ;
            run_frame(b0, b1, b2, g, ok);
            tests_run++;
            if ({ok, g, b0, b1, b2} !== {1'b1, 2'(1 << w), 8'h01, pl[w], 8'h05}) begin
                tests_failed++;
                $display("[TB] FAIL rr_frame%0d: got ok=%b gnt=%b bytes %h %h %h, expected 1 %b 01 %h 05",
                         f, ok, g, b0, b1, b2, 2'(1 << w), pl[w]);
            end
            if (f == 3) req = 2'b00;
            rep = ($urandom_range(0, 1) == 1) ? 8'h03 : 8'h04;
            give_reply(rep, 2, vp, tp, g, busy_at);
            exp_reply = rep;
            tests_run++;
            if ({reply, 32'(vp)} !== {rep, 32'd1}) begin
                tests_failed++;
                $display("[TB] FAIL rr_reply%0d: got reply=%h pulses=%0d, expected %h 1", f, reply, vp, rep);
            end
        end
    endtask

    task automatic test_arb_drop();
        bit seen;
        seen = 1'b0;
        req_payload = {8'h11, 8'h22};
        req = 2'b01;
        @(negedge CLK_50);
        req = 2'b00;
        repeat (8) begin
            @(negedge CLK_50);
            if (drive_en || gnt != '0) seen = 1'b1;
        end
        tests_run++;
        if ({seen, busy} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL arb_drop: got activity=%b busy=%b, expected 0 0", seen, busy);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] b0, b1, b2;
        logic [NREQ-1:0] g;
        bit ok;
        int w, vp, tp, glitch_pulses;
        logic busy_at;
        w = model_pick(2'b10);
        model_ptr = (w + 1) % NREQ;
        req_payload = {8'h5A, 8'hA5};
        req = 2'b10;
        run_frame(b0, b1, b2, g, ok);
        req = 2'b00;
        tests_run++;
        if ({ok, g, b1} !== {1'b1, 2'(1 << w), 8'h5A}) begin
            tests_failed++;
            $display("[TB] FAIL glitch_frame: got ok=%b gnt=%b payload=%h, expected 1 %b 5a", ok, g, b1, 2'(1 << w));
        end
        repeat (3) @(negedge CLK_50);
        data_in = 8'h03;
        @(negedge CLK_50);
        data_in = 8'h00;
        glitch_pulses = 0;
        repeat (8) begin
            @(negedge CLK_50);
            if (reply_valid) glitch_pulses++;
        end
        tests_run++;
        if ({32'(glitch_pulses), reply} !== {32'd0, exp_reply}) begin
            tests_failed++;
            $display("[TB] FAIL glitch_ignored: got pulses=%0d reply=%h, expected 0 %h", glitch_pulses, reply, exp_reply);
        end
        give_reply(8'h03, 1, vp, tp, g, busy_at);
        exp_reply = 8'h03;
        tests_run++;
        if ({reply, 32'(vp)} !== {8'h03, 32'd1}) begin
            tests_failed++;
            $display("[TB] FAIL glitch_then_yes: got reply=%h pulses=%0d, expected 03 1", reply, vp);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b0, b1, b2;
        logic [NREQ-1:0] g;
        bit ok;
        int w, n;
        w = model_pick(2'b01);
        model_ptr = (w + 1) % NREQ;
        req_payload = {8'h00, 8'h99};
        req = 2'b01;
        run_frame(b0, b1, b2, g, ok);
        req = 2'b00;
        // Counting from the TURN cycle; the pulse follows TIMEOUT waiting cycles after TURN
        n = 0;
        while (!timeout && n < TIMEOUT + 50) begin @(negedge CLK_50); n++; end
        tests_run++;
        if (n !== TIMEOUT + 1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycle: got %0d, expected %0d", n, TIMEOUT + 1);
        end
        tests_run++;
        if ({reply, busy, reply_valid, gnt} !== {exp_reply, 1'b0, 1'b0, 2'b00}) begin
            tests_failed++;
            $display("[TB] FAIL timeout_state: got reply=%h busy=%b rv=%b gnt=%b, expected %h 0 0 00",
                     reply, busy, reply_valid, gnt, exp_reply);
        end
        @(negedge CLK_50);
        tests_run++;
        if (timeout !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_pulse_width: got %b, expected 0", timeout); end
    endtask

    task automatic test_random();
        logic [7:0] b0, b1, b2, pl [NREQ], rep;
        logic [NREQ-1:0] g, r;
        bit ok;
        int w, vp, tp;
        logic busy_at;
        for (int it = 0; it < 8; it++) begin
            r = 2'($urandom_range(1, 3));
            for (int i = 0; i < NREQ; i++) begin
                case ($urandom_range(0, 3))
                    0:       pl[i] = 8'h01;
                    1:       pl[i] = 8'h05;
                    default: pl[i] = 8'($urandom);
                endcase
            end
            req_payload = {pl[1], pl[0]};
            w = model_pick(r);
            model_ptr = (w + 1) % NREQ;
            req = r;
            run_frame(b0, b1, b2, g, ok);
            req = 2'b00;
            tests_run++;
            if ({ok, g, b0, b1, b2} !== {1'b1, 2'(1 << w), 8'h01, pl[w], 8'h05}) begin
                tests_failed++;
                $display("[TB] FAIL rand_frame%0d: req=%b got ok=%b gnt=%b bytes %h %h %h, expected 1 %b 01 %h 05",
                         it, r, ok, g, b0, b1, b2, 2'(1 << w), pl[w]);
            end
            rep = ($urandom_range(0, 1) == 1) ? 8'h03 : 8'h04;
            give_reply(rep, int'($urandom_range(0, 10)), vp, tp, g, busy_at);
            exp_reply = rep;
            tests_run++;
            if ({reply, 32'(vp), 32'(tp), g} !== {rep, 32'd1, 32'd0, 2'b00}) begin
                tests_failed++;
                $display("[TB] FAIL rand_reply%0d: got reply=%h pulses=%0d timeouts=%0d gnt=%b, expected %h 1 0 00",
                         it, reply, vp, tp, g, rep);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int k;
        req_payload = {8'h00, 8'h6C};
        req = 2'b01;
        k = 0;
        while (!drive_en && k < 30) begin @(negedge CLK_50); k++; end
        inter_pulse();
        repeat (4) @(negedge CLK_50);
        tests_run++;
        if ({drive_en, data_out} !== {1'b1, 8'h6C}) begin
            tests_failed++;
            $display("[TB] FAIL mid_send_data: got drive_en=%b data_out=%h, expected 1 6c", drive_en, data_out);
        end
        SW = 1'b1;
        @(negedge CLK_50);
        tests_run++;
        if ({drive_en, gnt, busy, reply, data_out} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: got drive_en=%b gnt=%b busy=%b reply=%h data_out=%h, expected all 0",
                     drive_en, gnt, busy, reply, data_out);
        end
        req = 2'b00;
        SW = 1'b0;
        model_ptr = 0;
        exp_reply = 8'h00;
        req = 2'b11;
        repeat (3) @(negedge CLK_50);
        tests_run++;
        if (gnt !== 2'(1 << model_pick(2'b11))) begin
            tests_failed++;
            $display("[TB] FAIL ptr_after_reset: got %b, expected %b", gnt, 2'(1 << model_pick(2'b11)));
        end
        do_reset();
    endtask

`ifdef CM_LATENCY_CNT_EN
    task automatic test_latency();
        logic [7:0] b0, b1, b2;
        logic [NREQ-1:0] g;
        bit ok, seen;
        int k;
        req_payload = {8'h00, 8'h42};
        req = 2'b01;
        run_frame(b0, b1, b2, g, ok);
        req = 2'b00;
        repeat (500) @(negedge CLK_50);
        data_in = 8'h03;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            @(negedge CLK_50);
            k++;
            if (reply_valid) seen = 1'b1;
        end
        data_in = 8'h00;
        tests_run++;
        if (!seen || reply_cycles < 32'd498 || reply_cycles > 32'd502) begin
            tests_failed++;
            $display("[TB] FAIL latency_count: got valid=%b reply_cycles=%0d, expected 1 and 498..502", seen, reply_cycles);
        end
    endtask
`endif

    initial begin
        SW = 1'b1; CLK_inter = 1'b0; data_in = 8'h00; req = '0; req_payload = '0;
        test_reset();
        test_single_request();
        test_reply();
        test_round_robin();
        test_arb_drop();
        test_glitch();
        test_timeout();
        test_random();
        test_reset_mid_frame();
`ifdef CM_LATENCY_CNT_EN
        test_latency();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
